// File: rtl/gfx256_pixel_reader_if.sv
// Render-memory read bus between the pixel reader (master) and the framebuffer memory (slave).
// The 256-bit line fetch handshake: read_o is held until ack_i.
interface gfx256_pixel_reader_if #(
  parameter int MDW = 256
);
  logic           read_o;
  logic [31:0]    render_addr_o;
  logic [31:0]    render_sel_o;
  logic [MDW-1:0] render_dat_i;
  logic           ack_i;

  modport master (
    output read_o,
    output render_addr_o,
    output render_sel_o,
    input  render_dat_i,
    input  ack_i
  );

  modport slave (
    input  read_o,
    input  render_addr_o,
    input  render_sel_o,
    output render_dat_i,
    output ack_i
  );
endinterface

// File: rtl/gfx256_pixel_reader.sv
// Pixel readback: maps (x, y) to a 32-byte framebuffer line, fetches it through a
// single-line cache and returns the 8/16/32 bpp pixel zero-extended with a one-cycle ack.
module gfx256_pixel_reader #(
  parameter int point_width = 16,
  parameter int MDW         = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [31:0]            target_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [point_width-1:0] target_size_y_i,
  input  logic [5:0]             bpp_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic                   read_req_i,
  input  logic                   invalidate_i,
  output logic                   busy_o,
  output logic                   ack_o,
  output logic [31:0]            color_o,
  output logic                   oob_o,
  gfx256_pixel_reader_if.master  mem
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_ADDR   = 3'd2,
    ST_LOOKUP = 3'd3,
    ST_READ   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [point_width-1:0] x_q, x_d, y_q, y_d, sx_q, sx_d, sy_q, sy_d;
  logic [31:0]            base_q, base_d;
  logic [1:0]             bsh_q, bsh_d;        // log2(bytes per pixel)
  logic [31:0]            idx_q, idx_d;
  logic                   oob_pend_q, oob_pend_d;
  logic [31:0]            line_q, line_d;
  logic [7:0]             bitpos_q, bitpos_d;
  logic                   valid_q, valid_fill_s;
  logic                   valid_d;
  logic [31:0]            tag_q, tag_d;
  logic [MDW-1:0]         cache_q, cache_d;
  logic                   read_q, read_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            sel_q, sel_d;
  logic                   ack_q, ack_d;
  logic [31:0]            color_q, color_d;
  logic                   oob_q, oob_d;
  logic                   busy_q, busy_d;
  logic [31:0]            off_s;

  // Shift the line down to the pixel and keep only bpp bits.
  function automatic logic [31:0] extract_px(input logic [MDW-1:0] data,
                                             input logic [7:0]     bitpos,
                                             input logic [1:0]     bsh);
    logic [MDW-1:0] sh;
    sh = data >> bitpos;
    case (bsh)
      2'd0:    extract_px = {24'h000000, sh[7:0]};
      2'd1:    extract_px = {16'h0000, sh[15:0]};
      default: extract_px = sh[31:0];
    endcase
  endfunction

  assign off_s = idx_q << bsh_q;

  // Next-state and datapath decode for the request pipeline.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    base_d       = base_q;
    bsh_d        = bsh_q;
    idx_d        = idx_q;
    oob_pend_d   = oob_pend_q;
    line_d       = line_q;
    bitpos_d     = bitpos_q;
    valid_fill_s = valid_q;
    tag_d        = tag_q;
    cache_d      = cache_q;
    read_d       = read_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    ack_d        = 1'b0;
    color_d      = color_q;
    oob_d        = oob_q;

    case (state_q)
      ST_IDLE: begin
        if (read_req_i) begin
          x_d    = pixel_x_i;
          y_d    = pixel_y_i;
          sx_d   = target_size_x_i;
          sy_d   = target_size_y_i;
          base_d = target_base_i;
          case (bpp_i)
            6'd8:    bsh_d = 2'd0;
            6'd16:   bsh_d = 2'd1;
            default: bsh_d = 2'd2;
          endcase
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        idx_d      = 32'(y_q) * 32'(sx_q) + 32'(x_q);
        oob_pend_d = (x_q >= sx_q) | (y_q >= sy_q);
        state_d    = ST_ADDR;
      end
      ST_ADDR: begin
        line_d   = base_q + {off_s[31:5], 5'b00000};
        bitpos_d = {off_s[4:0], 3'b000};
        state_d  = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (oob_pend_q) begin
          color_d = 32'h0000_0000;
          oob_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else if (valid_q && !invalidate_i && (tag_q == line_q)) begin
          color_d = extract_px(cache_q, bitpos_q, bsh_q);
          oob_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          read_d  = 1'b1;
          addr_d  = line_q;
          sel_d   = 32'hFFFF_FFFF;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (mem.ack_i) begin
          cache_d      = mem.render_dat_i;
          tag_d        = line_q;
          valid_fill_s = 1'b1;
          color_d      = extract_px(mem.render_dat_i, bitpos_q, bsh_q);
          oob_d        = 1'b0;
          read_d       = 1'b0;
          sel_d        = 32'h0000_0000;
          ack_d        = 1'b1;
          state_d      = ST_RESP;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        read_d  = 1'b0;
        sel_d   = 32'h0000_0000;
        state_d = ST_IDLE;
      end
    endcase

    // Invalidate beats a same-cycle fill; the fetched colour is still returned.
    valid_d = invalidate_i ? 1'b0 : valid_fill_s;
    busy_d  = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      base_q     <= 32'h0000_0000;
      bsh_q      <= 2'd0;
      idx_q      <= 32'h0000_0000;
      oob_pend_q <= 1'b0;
      line_q     <= 32'h0000_0000;
      bitpos_q   <= 8'h00;
      valid_q    <= 1'b0;
      tag_q      <= 32'h0000_0000;
      cache_q    <= '0;
      read_q     <= 1'b0;
      addr_q     <= 32'h0000_0000;
      sel_q      <= 32'h0000_0000;
      ack_q      <= 1'b0;
      color_q    <= 32'h0000_0000;
      oob_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      base_q     <= base_d;
      bsh_q      <= bsh_d;
      idx_q      <= idx_d;
      oob_pend_q <= oob_pend_d;
      line_q     <= line_d;
      bitpos_q   <= bitpos_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      cache_q    <= cache_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      ack_q      <= ack_d;
      color_q    <= color_d;
      oob_q      <= oob_d;
      busy_q     <= busy_d;
    end
  end

  assign busy_o            = busy_q;
  assign ack_o             = ack_q;
  assign color_o           = color_q;
  assign oob_o             = oob_q;
  assign mem.read_o        = read_q;
  assign mem.render_addr_o = addr_q;
  assign mem.render_sel_o  = sel_q;

endmodule

// File: tb/tb_gfx256_pixel_reader.sv
// Randomised and directed bench for gfx256_pixel_reader, checked against a byte-level
// framebuffer model with a one-line cache predictor.
module tb_gfx256_pixel_reader;

  logic        clk;
  logic        rst_n;
  logic [31:0] target_base;
  logic [15:0] size_x, size_y;
  logic [5:0]  bpp;
  logic [15:0] px, py;
  logic        read_req, invalidate;
  logic        busy, ack;
  logic [31:0] color;
  logic        oob;

  int total = 0;
  int bad   = 0;

  logic [255:0] fb [logic [31:0]];
  logic         m_valid = 1'b0;
  logic [31:0]  m_tag   = 32'h0;

  gfx256_pixel_reader_if #(.MDW(256)) mem_if ();

  gfx256_pixel_reader #(.point_width(16), .MDW(256)) dut (
    .clk_i(clk), .rst_ni(rst_n), .target_base_i(target_base),
    .target_size_x_i(size_x), .target_size_y_i(size_y), .bpp_i(bpp),
    .pixel_x_i(px), .pixel_y_i(py), .read_req_i(read_req), .invalidate_i(invalidate),
    .busy_o(busy), .ack_o(ack), .color_o(color), .oob_o(oob), .mem(mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [255:0] get_line(input logic [31:0] a);
    logic [255:0] v;
    if (!fb.exists(a)) begin
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      fb[a] = v;
    end
    return fb[a];
  endfunction

  function automatic int unsigned bytes_of(input logic [5:0] b);
    if (b == 6'd8) return 1;
    else if (b == 6'd16) return 2;
    else return 4;
  endfunction

  // Framebuffer-level expectation plus single-line cache prediction.
  task automatic model_predict(input logic [15:0] x, input logic [15:0] y, input bit inv_on_ack,
                               output logic [31:0] ecol, output logic eoob,
                               output bit emiss, output logic [31:0] eline);
    logic [31:0]  a;
    int unsigned  nb;
    logic [255:0] ld;
    nb    = bytes_of(bpp);
    eoob  = (x >= size_x) || (y >= size_y);
    ecol  = 32'h0;
    emiss = 1'b0;
    eline = 32'h0;
    if (!eoob) begin
      a     = target_base + (32'(y) * 32'(size_x) + 32'(x)) * nb;
      eline = a & 32'hFFFF_FFE0;
      ld    = get_line(eline);
      for (int b = 0; b < int'(nb); b++) ecol[8*b +: 8] = ld[8*(int'(a[4:0]) + b) +: 8];
      emiss = !(m_valid && m_tag == eline);
      if (emiss) begin
        m_tag   = eline;
        m_valid = !inv_on_ack;
      end
    end
  endtask

  // Issue one request, act as memory, and report what the DUT did.
  task automatic run_req(input logic [15:0] x, input logic [15:0] y, input bit inv_on_ack,
                         input int ack_dly, output logic [31:0] col, output logic o,
                         output bit did_read, output logic [31:0] raddr,
                         output logic [31:0] rsel, output int lat, output int ack_cyc);
    int rd_cnt;
    bit acked;
    did_read = 1'b0; raddr = 32'h0; rsel = 32'h0; lat = -1; ack_cyc = -1;
    col = 32'h0; o = 1'b0; rd_cnt = 0; acked = 1'b0;
    @(negedge clk);
    px = x; py = y; read_req = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      read_req = 1'b0; mem_if.ack_i = 1'b0; invalidate = 1'b0;
      if (ack) begin
        lat = c; col = color; o = oob;
        break;
      end
      if (mem_if.read_o && !acked) begin
        if (!did_read) begin
          did_read = 1'b1; raddr = mem_if.render_addr_o; rsel = mem_if.render_sel_o;
        end
        if (rd_cnt >= ack_dly) begin
          mem_if.ack_i        = 1'b1;
          mem_if.render_dat_i = get_line(mem_if.render_addr_o);
          invalidate          = inv_on_ack;
          acked               = 1'b1;
          ack_cyc             = c;
        end
        rd_cnt++;
      end
    end
    mem_if.ack_i = 1'b0; invalidate = 1'b0;
  endtask

  task automatic pulse_inv();
    @(negedge clk); invalidate = 1'b1;
    @(negedge clk); invalidate = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, ack, oob, mem_if.read_o} !== 4'b0000 || color !== 32'h0 ||
        mem_if.render_addr_o !== 32'h0 || mem_if.render_sel_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b ack=%b oob=%b read=%b color=%h addr=%h sel=%h want all zero",
               busy, ack, oob, mem_if.read_o, color, mem_if.render_addr_o, mem_if.render_sel_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0;
  endtask

  task automatic test_miss_hit();
    logic [255:0] l;
    logic [31:0] col, raddr, rsel, ecol, eline;
    logic o, eoob;
    bit dr, emiss;
    int lat, ac;
    target_base = 32'h0000_1000; size_x = 16'd640; size_y = 16'd480; bpp = 6'd16;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    l[63:48] = 16'hBEEF;
    l[79:64] = 16'h1234;
    fb[32'h0000_1A00] = l;
    pulse_inv();
    model_predict(16'd3, 16'd2, 1'b0, ecol, eoob, emiss, eline);
    run_req(16'd3, 16'd2, 1'b0, 1, col, o, dr, raddr, rsel, lat, ac);
    total++; if (dr !== 1'b1) begin bad++; $display("FAIL miss_read got=%0d want=1", dr); end
    total++; if (raddr !== 32'h0000_1A00) begin bad++; $display("FAIL miss_addr got=%h want=00001a00", raddr); end
    total++; if (rsel !== 32'hFFFF_FFFF) begin bad++; $display("FAIL miss_sel got=%h want=ffffffff", rsel); end
    total++; if (lat !== ac + 1 || ac < 0) begin bad++; $display("FAIL miss_latency got=%0d want=%0d", lat, ac + 1); end
    total++; if (col !== 32'h0000_BEEF || o !== 1'b0) begin bad++; $display("FAIL miss_color got=%h/%b want=0000beef/0", col, o); end

    model_predict(16'd4, 16'd2, 1'b0, ecol, eoob, emiss, eline);
    run_req(16'd4, 16'd2, 1'b0, 0, col, o, dr, raddr, rsel, lat, ac);
    total++; if (dr !== 1'b0) begin bad++; $display("FAIL hit_noread got=%0d want=0", dr); end
    total++; if (lat !== 4) begin bad++; $display("FAIL hit_latency got=%0d want=4", lat); end
    total++; if (col !== 32'h0000_1234) begin bad++; $display("FAIL hit_color got=%h want=00001234", col); end

    model_predict(16'd640, 16'd0, 1'b0, ecol, eoob, emiss, eline);
    run_req(16'd640, 16'd0, 1'b0, 0, col, o, dr, raddr, rsel, lat, ac);
    total++; if (dr !== 1'b0 || lat !== 4) begin bad++; $display("FAIL oob_timing got read=%0d lat=%0d want read=0 lat=4", dr, lat); end
    total++; if (o !== 1'b1 || col !== 32'h0) begin bad++; $display("FAIL oob_flag got=%b/%h want=1/00000000", o, col); end
  endtask

  task automatic test_invalidate();
    logic [31:0] col, raddr, rsel, ecol, eline;
    logic o, eoob;
    bit dr, emiss;
    int lat, ac;
    pulse_inv();
    model_predict(16'd4, 16'd2, 1'b0, ecol, eoob, emiss, eline);
    run_req(16'd4, 16'd2, 1'b0, 2, col, o, dr, raddr, rsel, lat, ac);
    total++; if (dr !== 1'b1 || raddr !== 32'h0000_1A00) begin bad++; $display("FAIL inv_refetch got read=%0d addr=%h want 1/00001a00", dr, raddr); end
    total++; if (col !== 32'h0000_1234) begin bad++; $display("FAIL inv_color got=%h want=00001234", col); end
    pulse_inv();
    model_predict(16'd4, 16'd2, 1'b1, ecol, eoob, emiss, eline);
    run_req(16'd4, 16'd2, 1'b1, 0, col, o, dr, raddr, rsel, lat, ac);
    total++; if (dr !== 1'b1 || col !== 32'h0000_1234) begin bad++; $display("FAIL inv_on_fill got read=%0d color=%h want 1/00001234", dr, col); end
    model_predict(16'd4, 16'd2, 1'b0, ecol, eoob, emiss, eline);
    run_req(16'd4, 16'd2, 1'b0, 0, col, o, dr, raddr, rsel, lat, ac);
    total++; if (dr !== 1'b1) begin bad++; $display("FAIL inv_on_fill_next got read=%0d want=1", dr); end
  endtask

  task automatic test_bpp();
    logic [255:0] l;
    logic [31:0] col, raddr, rsel, ecol, eline;
    logic o, eoob;
    bit dr, emiss;
    int lat, ac;
    target_base = 32'h0; size_x = 16'd64; size_y = 16'd4;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    fb[32'h0] = l;
    pulse_inv();
    bpp = 6'd8;
    model_predict(16'd5, 16'd0, 1'b0, ecol, eoob, emiss, eline);
    run_req(16'd5, 16'd0, 1'b0, 0, col, o, dr, raddr, rsel, lat, ac);
    total++; if (dr !== 1'b1 || raddr !== 32'h0) begin bad++; $display("FAIL bpp8_addr got read=%0d addr=%h want 1/00000000", dr, raddr); end
    total++; if (col !== {24'h0, l[47:40]}) begin bad++; $display("FAIL bpp8_color got=%h want=%h", col, {24'h0, l[47:40]}); end
    bpp = 6'd32;
    model_predict(16'd5, 16'd0, 1'b0, ecol, eoob, emiss, eline);
    run_req(16'd5, 16'd0, 1'b0, 0, col, o, dr, raddr, rsel, lat, ac);
    total++; if (col !== l[191:160] || dr !== 1'b0) begin bad++; $display("FAIL bpp32_color got=%h read=%0d want=%h read=0", col, dr, l[191:160]); end
    bpp = 6'd24;
    model_predict(16'd5, 16'd0, 1'b0, ecol, eoob, emiss, eline);
    run_req(16'd5, 16'd0, 1'b0, 0, col, o, dr, raddr, rsel, lat, ac);
    total++; if (col !== l[191:160]) begin bad++; $display("FAIL bpp24_color got=%h want=%h", col, l[191:160]); end
  endtask

  task automatic test_reset_during_read();
    logic [31:0] col, raddr, rsel, ecol, eline;
    logic o, eoob;
    bit dr, emiss, seen;
    int lat, ac, n;
    target_base = 32'h0000_1000; size_x = 16'd640; size_y = 16'd480; bpp = 6'd16;
    @(negedge clk); px = 16'd10; py = 16'd3; read_req = 1'b1;
    @(posedge clk);
    @(negedge clk); read_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (mem_if.read_o) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rst_read_seen got=%0d want=1", seen); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (mem_if.read_o !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_drop got read=%b busy=%b want 0/0", mem_if.read_o, busy); end
    @(negedge clk); rst_n = 1'b1; m_valid = 1'b0;
    @(negedge clk); mem_if.ack_i = 1'b1; mem_if.render_dat_i = get_line(32'h0000_1A00);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); mem_if.ack_i = 1'b0;
      if (ack) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL rst_late_ack got acks=%0d want=0", n); end
    model_predict(16'd10, 16'd3, 1'b0, ecol, eoob, emiss, eline);
    run_req(16'd10, 16'd3, 1'b0, 1, col, o, dr, raddr, rsel, lat, ac);
    total++; if (dr !== 1'b1 || col !== ecol) begin bad++; $display("FAIL rst_next_miss got read=%0d color=%h want 1/%h", dr, col, ecol); end
  endtask

  task automatic test_busy();
    logic [31:0] ecol, eline;
    logic eoob;
    bit emiss, seen_busy;
    int acks;
    model_predict(16'd10, 16'd3, 1'b0, ecol, eoob, emiss, eline);
    @(negedge clk); px = 16'd10; py = 16'd3; read_req = 1'b1;
    acks = 0; seen_busy = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      if (seen_busy && !busy) read_req = 1'b0;
      if (ack) acks++;
      // ack_i held high throughout: only the READ-state one may count.
      mem_if.ack_i = 1'b1;
      mem_if.render_dat_i = get_line(mem_if.render_addr_o);
    end
    mem_if.ack_i = 1'b0; read_req = 1'b0;
    total++; if (acks !== 1) begin bad++; $display("FAIL busy_single_ack got=%0d want=1", acks); end
    total++; if (color !== ecol) begin bad++; $display("FAIL busy_color got=%h want=%h", color, ecol); end
  endtask

  task automatic test_random();
    logic [31:0] col, raddr, rsel, ecol, eline;
    logic o, eoob;
    bit dr, emiss, inv;
    int lat, ac, dly, elat;
    logic [15:0] x, y;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) begin
        target_base = 32'($urandom) & 32'hFFFF_FFE0;
        size_x = 16'($urandom_range(1, 40));
        size_y = 16'($urandom_range(1, 12));
        case ($urandom_range(0, 4))
          0: bpp = 6'd8;
          1: bpp = 6'd16;
          2: bpp = 6'd32;
          3: bpp = 6'd24;
          default: bpp = 6'd7;
        endcase
      end
      if ($urandom_range(0, 5) == 0) pulse_inv();
      x   = 16'($urandom_range(0, int'(size_x) + 1));
      y   = 16'($urandom_range(0, int'(size_y) + 1));
      inv = ($urandom_range(0, 4) == 0);
      dly = $urandom_range(0, 3);
      model_predict(x, y, inv, ecol, eoob, emiss, eline);
      run_req(x, y, inv, dly, col, o, dr, raddr, rsel, lat, ac);
      elat = emiss ? ac + 1 : 4;
      total++; if (col !== ecol || o !== eoob) begin bad++; $display("FAIL rnd_color i=%0d got=%h/%b want=%h/%b", i, col, o, ecol, eoob); end
      total++; if (dr !== emiss) begin bad++; $display("FAIL rnd_miss i=%0d got=%0d want=%0d", i, dr, emiss); end
      total++; if (lat !== elat || lat < 0) begin bad++; $display("FAIL rnd_latency i=%0d got=%0d want=%0d", i, lat, elat); end
      if (emiss) begin
        total++; if (raddr !== eline) begin bad++; $display("FAIL rnd_addr i=%0d got=%h want=%h", i, raddr, eline); end
      end
    end
  endtask

  initial begin
    target_base = 32'h0; size_x = 16'd0; size_y = 16'd0; bpp = 6'd8;
    px = 16'd0; py = 16'd0; read_req = 1'b0; invalidate = 1'b0;
    mem_if.ack_i = 1'b0; mem_if.render_dat_i = '0;
    test_reset();
    test_miss_hit();
    test_invalidate();
    test_bpp();
    test_reset_during_read();
    test_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gfx256_pixel_reader.md
Name: gfx256_pixel_reader

Overview:
- Read-side counterpart of the 256-bit pixel write path.
- Accepts a pixel coordinate request, computes the framebuffer line address and bit position, and fetches the 256-bit line over the render memory handshake.
- Extracts the pixel (8/16/32 bpp), returns it zero-extended with a one-cycle ack.
- Holds a single-line cache so that consecutive pixels in the same 32-byte line skip the memory read.
- Used by blit-source, colour-key and readback paths.

Parameters:
- point_width, 16, coordinate/size width in bits.
- MDW, 256, memory data width in bits; fixed, the line is 32 bytes.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; the block has one clock, and reset is asynchronous and active-low.
- target_base_i  in  32  framebuffer byte base address.
- target_size_x_i  in  point_width  width in pixels; also the row stride.
- target_size_y_i  in  point_width  height in pixels.
- bpp_i  in  6  bits per pixel: 8, 16 or 32; any other value is treated as 32.
- pixel_x_i  in  point_width  x coordinate.
- pixel_y_i  in  point_width  y coordinate.
- read_req_i  in  1  request strobe; sampled only in IDLE.
- invalidate_i  in  1  clears the line cache.
- busy_o  out  1  high whenever not in IDLE.
- ack_o  out  1  one-cycle response pulse.
- color_o  out  32  pixel value, zero-extended; valid while ack_o is high and held until the next ack.
- oob_o  out  1  coordinate out of bounds; valid with ack_o.
- read_o  out  1  memory read request.
- render_addr_o  out  32  32-byte-aligned line address.
- render_sel_o  out  32  byte selects; 32'hFFFFFFFF while read_o is high.
- render_dat_i  in  256  read data.
- ack_i  in  1  memory acknowledge.

Behaviour:
- Reset (asynchronous, rst_ni low) forces these values immediately:
  - state = IDLE.
  - read_o, ack_o, oob_o, busy_o = 0.
  - render_addr_o, render_sel_o, color_o = 0.
  - Cache valid = 0.
- A reset during READ drops read_o at once. An ack_i arriving after reset is ignored.
- State machine:
  - IDLE: on read_req_i, latch x, y, base, size and bpp, then go to CALC. Inputs may change after this edge.
  - CALC: register idx = y*size_x + x (32-bit, unsigned). Register oob = (x >= size_x) | (y >= size_y).
  - ADDR: compute off = idx << log2(bpp/8) and line = base + {off[31:5], 5'b0}, wrapping mod 2^32. Register bitpos = off[4:0]*8.
  - LOOKUP:
    - If oob: color = 0, oob_o = 1, go to RESP; no memory access.
    - Else if cache valid and cache tag == line: extract from the cached line, go to RESP.
    - Else: go to READ.
  - READ:
    - render_addr_o = line and render_sel_o = all ones, with read_o held high until ack_i.
    - On the edge where ack_i is sampled high: capture render_dat_i, write the cache (tag = line, valid = 1), register the extracted colour, clear read_o, go to RESP.
  - RESP: ack_o = 1 for exactly one cycle, then go to IDLE. color_o and oob_o are updated on entry to RESP.
- Extraction: color = (line_data >> bitpos) masked to bpp bits. bitpos is always aligned to the pixel size, so a pixel never straddles lines.
- Latency:
  - Hit or oob: ack_o is high in the 4th cycle after the accepting edge (request edge + 4).
  - Miss: ack_o is high in the cycle after the ack_i edge.
- read_req_i while busy_o is high is ignored; no queueing.
- ack_i outside READ is ignored.
- invalidate_i:
  - Clears valid on any cycle.
  - If asserted on the same edge as the READ ack_i fill, invalidate wins: the cache stays invalid, but the fetched colour is still returned.
  - If asserted during LOOKUP, that lookup is treated as a miss.
- There is no cache coherency with the write path. Users must pulse invalidate_i after writes to a region they later read.

Test Plan:
- Miss, 16 bpp: base 0x1000, size 640x480, x=3, y=2; memory returns bits [63:48] = 16'hBEEF -> read_o with render_addr_o = 0x1A00 and sel = 32'hFFFFFFFF; ack_o the cycle after ack_i; color_o = 0x0000BEEF; oob_o = 0.
- Hit: immediately request x=4, y=2, with the cached line holding bits [79:64] = 16'h1234 -> no read_o; ack_o at request edge + 4; color_o = 0x00001234.
- Out of bounds: x=640, y=0 -> no read_o; ack_o at +4; oob_o = 1; color_o = 0.
- Invalidate: pulse invalidate_i, then repeat x=4, y=2 -> read_o asserted again at 0x1A00. Repeat with invalidate_i on the same edge as the READ ack_i -> colour returned, next identical request still misses.
- bpp sweep at base 0, x=5, y=0:
  - 8 bpp: addr 0x0, bits [47:40].
  - 32 bpp: addr 0x0, bits [191:160].
  - bpp_i = 24: treated as 32, same result as 32 bpp.
- Reset and busy:
  - Drop rst_ni while read_o is high -> read_o = 0 immediately; a late ack_i produces no ack_o; the next request misses.
  - read_req_i while busy -> ignored, exactly one ack_o.
